joy_serial_rx: RTL and testbench

Deserialiser for the two-player shift-register joystick adapter on the JOY_CLK / JOY_LOAD / JOY_DATA pins. It generates the adapter clock and load strobe and shifts in a fixed 26-slot frame. Each slot is mapped to a bit of two 12-bit active-low joystick words. An optional two-frame agreement filter is applied before the words are presented. The block sits directly upstream of the MSX core top level, which consumes `joystick1[5:0]` / `joystick2[5:0]` for pJoyA/pJoyB and the mouse/joystick selection logic.

---
 rtl/joy_serial_rx.sv | 143 ++++++++++++++
 tb/tb_joy_serial_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_rx.sv
// joy_serial_rx
// Deserialiser for the two-player shift-register joystick adapter.
// Generates the adapter shift clock and active-low load strobe, shifts in a
// 26-slot frame, scatters the slots into two 12-bit active-low joystick words
// and (optionally) commits a frame only after two identical frames in a row.
//
// Ports:
//   clk_sys      in   system clock, all logic on rising edge
//   reset_n      in   synchronous active-low reset
//   joy_data     in   serial data from the adapter, 1 = released
//   joy_clk      out  adapter shift clock (registered)
//   joy_load     out  adapter parallel load, active low (registered)
//   joystick1    out  player-1 word, active low
//   joystick2    out  player-2 word, active low
//   frame_strobe out  one-cycle pulse aligned with each commit
module joy_serial_rx #(
  parameter int CLK_DIV = 16,
  parameter int FILTER  = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic        frame_strobe
);

  localparam int               DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       LAST_SLOT = 5'd25;

  // Destination of one serial slot: which word and which bit.
  typedef struct packed {
    logic       hit;
    logic       p2;
    logic [3:0] idx;
  } slot_map_t;

  function automatic slot_map_t slot_map(input logic [4:0] s);
    slot_map_t m;
    m = '{hit: 1'b0, p2: 1'b0, idx: 4'd0};
    case (s)
      5'd2:  m = '{1'b1, 1'b0, 4'd8};
      5'd3:  m = '{1'b1, 1'b0, 4'd6};
      5'd4:  m = '{1'b1, 1'b0, 4'd5};
      5'd5:  m = '{1'b1, 1'b0, 4'd4};
      5'd6:  m = '{1'b1, 1'b0, 4'd3};
      5'd7:  m = '{1'b1, 1'b0, 4'd2};
      5'd8:  m = '{1'b1, 1'b0, 4'd1};
      5'd9:  m = '{1'b1, 1'b0, 4'd0};
      5'd10: m = '{1'b1, 1'b1, 4'd8};
      5'd11: m = '{1'b1, 1'b1, 4'd6};
      5'd12: m = '{1'b1, 1'b1, 4'd5};
      5'd13: m = '{1'b1, 1'b1, 4'd4};
      5'd14: m = '{1'b1, 1'b1, 4'd3};
      5'd15: m = '{1'b1, 1'b1, 4'd2};
      5'd16: m = '{1'b1, 1'b1, 4'd1};
      5'd17: m = '{1'b1, 1'b1, 4'd0};
      5'd18: m = '{1'b1, 1'b1, 4'd10};
      5'd19: m = '{1'b1, 1'b1, 4'd11};
      5'd20: m = '{1'b1, 1'b1, 4'd9};
      5'd21: m = '{1'b1, 1'b1, 4'd7};
      5'd22: m = '{1'b1, 1'b0, 4'd10};
      5'd23: m = '{1'b1, 1'b0, 4'd11};
      5'd24: m = '{1'b1, 1'b0, 4'd9};
      5'd25: m = '{1'b1, 1'b0, 4'd7};
      default: ;
    endcase
    return m;
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [4:0]       bit_next;
  logic [11:0]      sh1, sh2;
  logic [11:0]      cand1, cand2;
  logic [23:0]      prev;
  logic             prev_valid;
  logic             tick;
  logic             frame_done;
  logic             commit;
  slot_map_t        sm;

  always_comb begin
    // tick = the cycle in which joy_clk is about to go 0->1
    tick       = (div_cnt == DIV_LAST) && !joy_clk;
    sm         = slot_map(bit_cnt);
    // shadow words with the current slot's bit merged in, so the slot-25
    // bit is part of the candidate on the completing tick
    cand1      = sh1;
    cand2      = sh2;
    if (sm.hit) begin
      if (sm.p2) cand2[sm.idx] = joy_data;
      else       cand1[sm.idx] = joy_data;
    end
    bit_next   = (bit_cnt == LAST_SLOT) ? 5'd0 : bit_cnt + 5'd1;
    frame_done = tick && (bit_cnt == LAST_SLOT);
    commit     = frame_done &&
                 ((FILTER == 0) || (prev_valid && ({cand1, cand2} == prev)));
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      div_cnt      <= '0;
      joy_clk      <= 1'b0;
      bit_cnt      <= 5'd0;
      joy_load     <= 1'b0;
      sh1          <= 12'hFFF;
      sh2          <= 12'hFFF;
      prev         <= 24'hFFFFFF;
      prev_valid   <= 1'b0;
      joystick1    <= 12'hFFF;
      joystick2    <= 12'hFFF;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        joy_clk <= ~joy_clk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (tick) begin
        bit_cnt  <= bit_next;
        joy_load <= (bit_next != 5'd0);
        sh1      <= cand1;
        sh2      <= cand2;
      end
      if (frame_done) begin
        prev       <= {cand1, cand2};
        prev_valid <= 1'b1;
      end
      if (commit) begin
        joystick1    <= cand1;
        joystick2    <= cand2;
        frame_strobe <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_rx.sv
// Testbench for joy_serial_rx. Three instances:
//   0: CLK_DIV=16 FILTER=1  reset, filter and mid-frame reset sequences
//   1: CLK_DIV=2  FILTER=0  single-slot table and wrap/period timing
//   2: CLK_DIV=2  FILTER=1  full slot walk plus random frames vs a model
// A behavioural adapter per instance counts joy_clk rises to find the slot
// and drives the frame bit for that slot; frames are listed per instance.
module tb_joy_serial_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n = 3'b000;
  logic [2:0]       jd, jclk, jload, stb;
  logic [2:0][11:0] j1, j2;

  joy_serial_rx #(.CLK_DIV(16), .FILTER(1)) u_f (
    .clk_sys(clk), .reset_n(rst_n[0]), .joy_data(jd[0]), .joy_clk(jclk[0]),
    .joy_load(jload[0]), .joystick1(j1[0]), .joystick2(j2[0]), .frame_strobe(stb[0]));
  joy_serial_rx #(.CLK_DIV(2), .FILTER(0)) u_n (
    .clk_sys(clk), .reset_n(rst_n[1]), .joy_data(jd[1]), .joy_clk(jclk[1]),
    .joy_load(jload[1]), .joystick1(j1[1]), .joystick2(j2[1]), .frame_strobe(stb[1]));
  joy_serial_rx #(.CLK_DIV(2), .FILTER(1)) u_m (
    .clk_sys(clk), .reset_n(rst_n[2]), .joy_data(jd[2]), .joy_clk(jclk[2]),
    .joy_load(jload[2]), .joystick1(j1[2]), .joystick2(j2[2]), .frame_strobe(stb[2]));

  localparam logic [25:0] ONES = '1;

  typedef struct {
    int          slot;
    logic [11:0] e1;
    logic [11:0] e2;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [25:0] seq [3][128];
  int          slot [3];
  int          fnum [3];
  int          scnt [3];
  logic [2:0]  jclk_q;
  logic [23:0] expq [$];
  logic [23:0] e_m;
  bit          mon_m = 1'b0;

  int          k, errs_c, errs_l, nst, nf, nexp, ticks;
  int          st [3];
  logic [25:0] f, fa, fb, fc;
  logic [31:0] r;
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slot -> word bit, straight from the adapter wiring table.
  function automatic logic [23:0] map_frame(input logic [25:0] fr);
    int          ord [12];
    logic [11:0] w1, w2;
    int          kk;
    ord = '{8, 6, 5, 4, 3, 2, 1, 0, 10, 11, 9, 7};
    w1  = 12'hFFF;
    w2  = 12'hFFF;
    for (int s = 2; s < 26; s++) begin
      kk = s - 2;
      if (kk < 8)       w1[ord[kk]]      = fr[s];
      else if (kk < 20) w2[ord[kk - 8]]  = fr[s];
      else              w1[ord[kk - 12]] = fr[s];
    end
    return {w1, w2};
  endfunction

  // Adapter model + strobe monitor + scoreboard for instance 2.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n[d]) begin
        slot[d] = 0;
        fnum[d] = 0;
      end else if (jclk[d] && !jclk_q[d]) begin
        if (slot[d] == 25) begin
          slot[d] = 0;
          if (fnum[d] < 127) fnum[d]++;
        end else begin
          slot[d]++;
        end
      end
      jclk_q[d] = jclk[d];
      jd[d]     = seq[d][fnum[d]][slot[d]];
      if (stb[d]) scnt[d]++;
    end
    if (mon_m && stb[2]) begin
      if (expq.size() == 0) begin
        chk("m_extra_strobe", 32'd1, 32'd0);
      end else begin
        e_m = expq.pop_front();
        chk("m_commit", {8'h0, j1[2], j2[2]}, {8'h0, e_m});
        if (scnt[2] <= 24) chk("m_walk_one_zero", $countones({j1[2], j2[2]}), 23);
      end
    end
  end

  task automatic reset_dut(input int d);
    @(negedge clk);
    rst_n[d] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n[d] = 1'b1;
    scnt[d]  = 0;
  endtask

  // Cycles (posedges) from now until frame_strobe is seen; -1 on timeout.
  task automatic wait_strobe(input int d, input int bound, output int kk);
    kk = 0;
    do begin
      @(posedge clk); #1;
      kk++;
    end while (!stb[d] && kk < bound);
    if (!stb[d]) kk = -1;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++)
      for (int q = 0; q < 128; q++) seq[d][q] = ONES;

    tbl[0] = '{9,  12'hFFE, 12'hFFF};
    tbl[1] = '{19, 12'hFFF, 12'h7FF};
    tbl[2] = '{21, 12'hFFF, 12'hF7F};
    tbl[3] = '{2,  12'hEFF, 12'hFFF};
    tbl[4] = '{10, 12'hFFF, 12'hEFF};
    tbl[5] = '{25, 12'hF7F, 12'hFFF};
    tbl[6] = '{0,  12'hFFF, 12'hFFF};
    tbl[7] = '{17, 12'hFFF, 12'hFFE};

    // ---- reset state and first tick ----
    reset_dut(0);
    #1;
    chk("rst_j1", j1[0], 12'hFFF);
    chk("rst_j2", j2[0], 12'hFFF);
    chk("rst_strobe", stb[0], 1'b0);
    chk("rst_load", jload[0], 1'b0);
    chk("rst_clk", jclk[0], 1'b0);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!jclk[0] && k < 100);
    chk("rst_first_rise_cycle", k, 16);
    chk("rst_load_at_tick", jload[0], 1'b1);

    // ---- filter: A, B, B -> single commit after second B ----
    fa = ONES; fa[2] = 1'b0;
    fb = ONES; fb[3] = 1'b0;
    seq[0][0] = fa; seq[0][1] = fb; seq[0][2] = fb;
    reset_dut(0);
    wait_strobe(0, 3000, k);
    chk("flt_commit_cycle", k, 2480);
    chk("flt_j1", j1[0], 12'hFBF);
    chk("flt_j2", j2[0], 12'hFFF);
    repeat (3) @(posedge clk);
    #1 chk("flt_strobe_count", scnt[0], 1);

    // ---- reset at slot 14 of an all-zero frame pair ----
    for (int q = 0; q < 128; q++) seq[0][q] = ONES;
    seq[0][0] = '0; seq[0][1] = '0;
    reset_dut(0);
    k = 0;
    while (!(fnum[0] == 1 && slot[0] == 14) && k < 3000) begin @(negedge clk); k++; end
    chk("mid_reach_slot14", (k < 3000), 1'b1);
    rst_n[0] = 1'b0;
    fc = ONES; fc[5] = 1'b0;
    seq[0][0] = fc; seq[0][1] = fc;
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    #1;
    chk("mid_j1", j1[0], 12'hFFF);
    chk("mid_j2", j2[0], 12'hFFF);
    chk("mid_no_strobe", scnt[0], 0);
    chk("mid_load_low", jload[0], 1'b0);
    chk("mid_clk_low", jclk[0], 1'b0);
    wait_strobe(0, 2000, k);
    chk("mid_recommit_cycle", k, 1648);
    chk("mid_recommit_j1", j1[0], 12'hFEF);
    chk("mid_recommit_j2", j2[0], 12'hFFF);

    // ---- single-slot table, FILTER=0 ----
    for (int i = 0; i < 8; i++) begin
      f = ONES;
      f[tbl[i].slot] = 1'b0;
      seq[1][0] = f;
      reset_dut(1);
      wait_strobe(1, 300, k);
      chk($sformatf("tbl%0d_slot%0d_latency", i, tbl[i].slot), k, 102);
      chk($sformatf("tbl%0d_slot%0d_j1", i, tbl[i].slot), j1[1], tbl[i].e1);
      chk($sformatf("tbl%0d_slot%0d_j2", i, tbl[i].slot), j2[1], tbl[i].e2);
      repeat (4) @(posedge clk);
      #1 chk($sformatf("tbl%0d_strobes", i), scnt[1], 1);
    end

    // ---- wrap / period, CLK_DIV=2, 3 frames ----
    seq[1][0] = ONES;
    reset_dut(1);
    errs_c = 0; errs_l = 0; nst = 0;
    for (int kk = 1; kk <= 320; kk++) begin
      @(posedge clk); #1;
      if (jclk[1] !== 1'((kk / 2) % 2)) errs_c++;
      ticks = (kk + 2) / 4;
      if (jload[1] !== ((ticks % 26) != 0)) errs_l++;
      if (stb[1]) begin
        if (nst < 3) st[nst] = kk;
        nst++;
      end
    end
    chk("wrap_clk_errs", errs_c, 0);
    chk("wrap_load_errs", errs_l, 0);
    chk("wrap_strobes", nst, 3);
    chk("wrap_first_strobe", st[0], 102);
    chk("wrap_gap1", st[1] - st[0], 104);
    chk("wrap_gap2", st[2] - st[1], 104);

    // ---- full slot walk + random frames, FILTER=1 ----
    nf = 1;
    seq[2][0] = ONES;
    for (int s = 2; s < 26; s++) begin
      f = ONES; f[s] = 1'b0;
      seq[2][nf] = f; seq[2][nf + 1] = f;
      nf += 2;
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0 && $urandom_range(0, 1) == 1) begin
        f = seq[2][nf - 1];
      end else begin
        r = $urandom();
        f = r[25:0];
      end
      seq[2][nf] = f;
      nf++;
    end
    expq.delete();
    for (int q = 1; q < nf; q++)
      if (seq[2][q] == seq[2][q - 1]) expq.push_back(map_frame(seq[2][q]));
    nexp = expq.size();
    reset_dut(2);
    mon_m = 1'b1;
    k = 0;
    while (fnum[2] < nf && k < 20000) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    mon_m = 1'b0;
    chk("m_reached_end", (fnum[2] >= nf), 1'b1);
    chk("m_pending_commits", expq.size(), 0);
    chk("m_commit_count", scnt[2], nexp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
